// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit register with hold, load, shift, rotate and
// clear, plus a burst sequencer that runs n_shift serial shifts with a
// busy/done handshake.
// Optional build macro SHIFT_CARRY_EN adds a carry output that holds the bit
// most recently shifted or rotated out.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | manual ops accepted when en=1; start launches a burst
// SHIFT | one serial shift per cycle until the counter reaches 1
// DONE  | single-cycle done pulse, then back to IDLE

module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             si_r,
   input  logic             si_l,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] n_shift,
   output logic [WIDTH-1:0] q,
   output logic             so_r,
   output logic             so_l,
   output logic             busy,
   output logic             done
`ifdef SHIFT_CARRY_EN
   ,
   output logic             carry
`endif
);

   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ROR   = 3'b100;
   localparam logic [2:0] M_ROL   = 3'b101;
   localparam logic [2:0] M_CLEAR = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             dir_r;

   logic [WIDTH-1:0] shr_val;
   logic [WIDTH-1:0] shl_val;
   logic [WIDTH-1:0] ror_val;
   logic [WIDTH-1:0] rol_val;

   // Candidate next values for each shift/rotate flavour, all taken from q.
   always_comb begin
      shr_val = {si_r, q[WIDTH-1:1]};
      shl_val = {q[WIDTH-2:0], si_l};
      ror_val = {q[0], q[WIDTH-1:1]};
      rol_val = {q[WIDTH-2:0], q[WIDTH-1]};
   end

   assign so_r = q[0];
   assign so_l = q[WIDTH-1];

   // Sequencer and register bank; start has priority over a manual op in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         dir_r <= 1'b0;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SHIFT_CARRY_EN
         carry <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (n_shift != '0) begin
                     cnt   <= n_shift;
                     dir_r <= dir;
                     busy  <= 1'b1;
                     state <= SHIFT;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else if (en) begin
                  case (mode)
                     M_SHR: begin
                        q <= shr_val;
`ifdef SHIFT_CARRY_EN
                        carry <= q[0];
`endif
                     end
                     M_SHL: begin
                        q <= shl_val;
`ifdef SHIFT_CARRY_EN
                        carry <= q[WIDTH-1];
`endif
                     end
                     M_LOAD: begin
                        q <= d;
`ifdef SHIFT_CARRY_EN
                        carry <= 1'b0;
`endif
                     end
                     M_ROR: begin
                        q <= ror_val;
`ifdef SHIFT_CARRY_EN
                        carry <= q[0];
`endif
                     end
                     M_ROL: begin
                        q <= rol_val;
`ifdef SHIFT_CARRY_EN
                        carry <= q[WIDTH-1];
`endif
                     end
                     M_CLEAR: begin
                        q <= '0;
`ifdef SHIFT_CARRY_EN
                        carry <= 1'b0;
`endif
                     end
                     default: ;
                  endcase
               end
            end
            SHIFT: begin
               if (dir_r) begin
                  q <= shl_val;
`ifdef SHIFT_CARRY_EN
                  carry <= q[WIDTH-1];
`endif
               end else begin
                  q <= shr_val;
`ifdef SHIFT_CARRY_EN
                  carry <= q[0];
`endif
               end
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised WIDTH-bit edge-triggered register bank and the next generation of the lab's storage elements.
- Supports hold, parallel load, logical shift, rotate and clear.
- An auto-shift sequencer performs N shifts in a burst, with busy/done handshake.
- Used as a serializer/deserializer building block in later lab modules.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- CNT_W, 4, width of burst shift count; max burst is 2^CNT_W-1 shifts

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- en  in  1  manual-operation enable; ignored while busy
- mode  in  3  000 hold, 001 shr, 010 shl, 011 load, 100 ror, 101 rol, 110 clear, 111 hold
- si_r  in  1  serial in for right shift; enters q[WIDTH-1]
- si_l  in  1  serial in for left shift; enters q[0]
- d  in  WIDTH  parallel load data
- start  in  1  burst request, single-cycle pulse
- dir  in  1  burst direction: 0 right, 1 left; sampled with start
- n_shift  in  CNT_W  burst length, sampled with start
- q  out  WIDTH  register contents
- so_r  out  1  q[0], combinational from q
- so_l  out  1  q[WIDTH-1], combinational from q
- busy  out  1  high while burst active
- done  out  1  one-cycle pulse when burst completes

Behaviour:
- Reset: reset_n low forces asynchronously q=0, busy=0, done=0, counter=0, FSM=IDLE. This holds mid-burst too: the burst is aborted and no done pulse follows.
- Manual ops (FSM IDLE, en=1), applied on the rising edge:
  - shr: q <= {si_r, q[WIDTH-1:1]}
  - shl: q <= {q[WIDTH-2:0], si_l}
  - ror: q <= {q[0], q[WIDTH-1:1]}
  - rol: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - load: q <= d
  - clear: q <= 0
  - hold (000/111): q unchanged
- en=0 in IDLE: q holds.
- Latency: one clock from sampled inputs to updated q; no combinational path from inputs to q.
- FSM states:
  - IDLE: start=1 and n_shift!=0 latches dir and n_shift into the counter; goes to SHIFT and sets busy=1 on the next edge.
    - start=1 with n_shift=0 goes straight to DONE: done pulses and q is unchanged.
    - start and en both high in the same IDLE cycle: start wins; the manual op is discarded.
  - SHIFT: each cycle performs one shr (dir=0, using si_r) or shl (dir=1, using si_l) and decrements the counter. The cycle with counter==1 performs the final shift and moves to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Burst timing:
  - a burst of N shifts keeps busy high for exactly N cycles;
  - done asserts the cycle after the last shift.
- While busy: start, en, mode, d, dir and n_shift are ignored. Serial inputs are sampled every SHIFT cycle.
- Boundaries:
  - max n_shift = 2^CNT_W-1 is allowed;
  - N >= WIDTH fully replaces contents with serial-in data.

Optional Feature:
- Macro: SHIFT_CARRY_EN.
- Defined:
  - adds output port carry (1 bit), reset 0;
  - on every shift (manual or burst) carry <= the bit shifted out: q[0] for shr/ror, q[WIDTH-1] for shl/rol;
  - load and clear set carry=0;
  - hold leaves carry unchanged.
- Undefined: the carry port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-burst: WIDTH=8, load 8'hA5, start dir=0 n_shift=5, assert reset_n=0 after 2 shift cycles -> q=0, busy=0 immediately (asynchronous); no done pulse after release.
- Manual ops: load 8'h81; ror -> 8'hC0; rol -> 8'h81; shl si_l=0 -> 8'h02; shr si_r=1 -> 8'h81; clear -> 8'h00; en=0 with mode=011 d=8'hFF -> q stays 8'h00.
- Burst right: load 8'hF0, start dir=0 n_shift=4 si_r=0 -> busy high for exactly 4 cycles, q=8'h0F, done one-cycle pulse on the following cycle; q then holds.
- Burst ignores inputs: start dir=1 n_shift=3 si_l=1 from q=8'h00, toggle en/mode=011/d=8'hAA during busy -> q=8'h07, d never loaded.
- Zero-length burst and priority: start with n_shift=0 -> busy never high, done pulses next cycle, q unchanged. Start and en mode=110 together -> burst runs, no clear.
- SHIFT_CARRY_EN defined: q=8'h01, shr si_r=0 -> carry=1, q=8'h00; load 8'h80 -> carry=0; shl -> carry=1, q=8'h00.
